// File: rtl/txpll_lock_sequencer.sv
// +----------------------------------------------------------------------------+
// | txpll_lock_sequencer: TX PLL lock qualification and lane reset release.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module txpll_lock_sequencer #(
  parameter int STABLE_CYCLES   = 1024,
  parameter int LANE_RST_CYCLES = 64,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       PLL_LOCK,
  input  logic       CLR_FAULT,
  output logic       LANE_TX_RST_N,
  output logic       LANE_PCS_RST_N,
  output logic       READY,
  output logic       FAULT,
  output logic [7:0] LOSS_CNT,
  output logic [2:0] STATE
);

  localparam int MAX_A      = (STABLE_CYCLES > LANE_RST_CYCLES) ? STABLE_CYCLES : LANE_RST_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] LANE_LAST    = TW'(LANE_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_LANE_RST  = 3'd3,
    S_PCS_RST   = 3'd4,
    S_RUN       = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [TW-1:0] timer_inc;
  logic [7:0]    loss_nxt;
  logic          lock_meta;
  logic          lock_s;
  logic          lost;

  // Two-flop synchronizer; nothing downstream looks at raw PLL_LOCK.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_s    <= lock_meta;
    end
  end

  // Saturating increment keeps the shared timer from ever wrapping.
  assign timer_inc = (timer == {TW{1'b1}}) ? timer : timer + 1'b1;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer_inc;
    loss_nxt  = LOSS_CNT;
    lost      = 1'b0;

    case (state)
      S_IDLE: begin
        timer_nxt = '0;
        if (ENABLE) begin
          state_nxt = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = S_STABLE;
          timer_nxt = '0;
        end else if (timer == TIMEOUT_LAST) begin
          state_nxt = S_FAULT;
          timer_nxt = '0;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          timer_nxt = '0;
        end else if (timer == STABLE_LAST) begin
          state_nxt = S_LANE_RST;
          timer_nxt = '0;
        end
      end
      S_LANE_RST: begin
        if (!lock_s) begin
          lost = 1'b1;
        end else if (timer == LANE_LAST) begin
          state_nxt = S_PCS_RST;
          timer_nxt = '0;
        end
      end
      S_PCS_RST: begin
        if (!lock_s) begin
          lost = 1'b1;
        end else if (timer == LANE_LAST) begin
          state_nxt = S_RUN;
          timer_nxt = '0;
        end
      end
      S_RUN: begin
        timer_nxt = '0;
        if (!lock_s) begin
          lost = 1'b1;
        end
      end
      S_FAULT: begin
        timer_nxt = '0;
        if (CLR_FAULT) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        timer_nxt = '0;
      end
    endcase

    if (lost) begin
      state_nxt = S_WAIT_LOCK;
      timer_nxt = '0;
      loss_nxt  = (LOSS_CNT == 8'hFF) ? LOSS_CNT : LOSS_CNT + 8'd1;
    end

    // Dropping ENABLE overrides a simultaneous lock loss, so no count is taken.
    if (!ENABLE && (state != S_FAULT)) begin
      state_nxt = S_IDLE;
      timer_nxt = '0;
      loss_nxt  = LOSS_CNT;
    end
  end

  // Outputs decode the next state so they change in the same update as STATE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= S_IDLE;
      timer          <= '0;
      LOSS_CNT       <= 8'd0;
      READY          <= 1'b0;
      FAULT          <= 1'b0;
      LANE_TX_RST_N  <= 1'b0;
      LANE_PCS_RST_N <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      LOSS_CNT       <= loss_nxt;
      READY          <= (state_nxt == S_RUN);
      FAULT          <= (state_nxt == S_FAULT);
      LANE_TX_RST_N  <= (state_nxt == S_PCS_RST) || (state_nxt == S_RUN);
      LANE_PCS_RST_N <= (state_nxt == S_RUN);
    end
  end

  assign STATE = state;

endmodule

`default_nettype wire

// File: tb/tb_txpll_lock_sequencer.sv
// Bench for txpll_lock_sequencer: expected state transitions are queued as
// stimulus is driven and matched against transitions observed on STATE.
`default_nettype none

module tb_txpll_lock_sequencer;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_STAB  = 3'd2;
  localparam logic [2:0] ST_LANE  = 3'd3;
  localparam logic [2:0] ST_PCS   = 3'd4;
  localparam logic [2:0] ST_RUN   = 3'd5;
  localparam logic [2:0] ST_FAULT = 3'd6;

  logic       CLK;
  logic       RESET_N;
  logic       ENABLE;
  logic       PLL_LOCK;
  logic       CLR_FAULT;
  logic       LANE_TX_RST_N;
  logic       LANE_PCS_RST_N;
  logic       READY;
  logic       FAULT;
  logic [7:0] LOSS_CNT;
  logic [2:0] STATE;

  typedef struct packed {
    logic [2:0]  st;
    logic        rdy;
    logic        tx;
    logic        pcs;
    logic        flt;
    logic [7:0]  loss;
    logic [31:0] cyc;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       obs_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [2:0] prev_st = 3'bxxx;

  txpll_lock_sequencer #(
    .STABLE_CYCLES  (16),
    .LANE_RST_CYCLES(4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .ENABLE        (ENABLE),
    .PLL_LOCK      (PLL_LOCK),
    .CLR_FAULT     (CLR_FAULT),
    .LANE_TX_RST_N (LANE_TX_RST_N),
    .LANE_PCS_RST_N(LANE_PCS_RST_N),
    .READY         (READY),
    .FAULT         (FAULT),
    .LOSS_CNT      (LOSS_CNT),
    .STATE         (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Record every STATE change with the outputs seen alongside it.
  always @(negedge CLK) begin
    if (STATE !== prev_st) begin
      obs_q.push_back('{st: STATE, rdy: READY, tx: LANE_TX_RST_N, pcs: LANE_PCS_RST_N,
                        flt: FAULT, loss: LOSS_CNT, cyc: cyc});
      prev_st = STATE;
    end
  end

  function automatic rec_t mk(input logic [2:0] st, input logic [7:0] loss, input int c);
    rec_t r;
    r.st   = st;
    r.rdy  = (st == ST_RUN);
    r.tx   = (st == ST_PCS) || (st == ST_RUN);
    r.pcs  = (st == ST_RUN);
    r.flt  = (st == ST_FAULT);
    r.loss = loss;
    r.cyc  = c;
    return r;
  endfunction

  function automatic string rstr(input rec_t r);
    return $sformatf("st=%0d rdy=%0b tx=%0b pcs=%0b flt=%0b loss=%0d cyc=%0d",
                     r.st, r.rdy, r.tx, r.pcs, r.flt, r.loss, r.cyc);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    RESET_N   = 1'b0;
    ENABLE    = 1'b0;
    PLL_LOCK  = 1'b0;
    CLR_FAULT = 1'b0;
    run_cycles(3);
    checks++;
    if (STATE !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", STATE);
    end
    checks++;
    if ({READY, FAULT, LANE_TX_RST_N, LANE_PCS_RST_N} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0000",
                         {READY, FAULT, LANE_TX_RST_N, LANE_PCS_RST_N});
    end
    checks++;
    if (LOSS_CNT !== 8'd0) begin
      errors++; $display("FAIL reset_loss: got %0d expected 0", LOSS_CNT);
    end
    RESET_N = 1'b1;
    run_cycles(3);
    checks++;
    if (STATE !== ST_IDLE) begin
      errors++; $display("FAIL idle_disabled: got %0d expected 0", STATE);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_bringup();
    rec_t e, o;
    int c;
    step();
    ENABLE   = 1'b1;
    PLL_LOCK = 1'b1;
    c = cyc;
    exp_q.push_back(mk(ST_WAIT, 8'd0, c + 1));
    exp_q.push_back(mk(ST_STAB, 8'd0, c + 3));
    exp_q.push_back(mk(ST_LANE, 8'd0, c + 19));
    exp_q.push_back(mk(ST_PCS,  8'd0, c + 23));
    exp_q.push_back(mk(ST_RUN,  8'd0, c + 27));
    run_cycles(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL bringup: got no transition, expected %s", rstr(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL bringup: got %s expected %s", rstr(o), rstr(e));
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL bringup_extra: got %0d extra transitions expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_lock_glitch();
    rec_t e, o;
    int c;
    step();
    ENABLE = 1'b0;
    c = cyc;
    exp_q.push_back(mk(ST_IDLE, 8'd0, c + 1));
    step();
    ENABLE = 1'b1;
    c = cyc;
    exp_q.push_back(mk(ST_WAIT, 8'd0, c + 1));
    exp_q.push_back(mk(ST_STAB, 8'd0, c + 2));
    exp_q.push_back(mk(ST_WAIT, 8'd0, c + 13));
    exp_q.push_back(mk(ST_STAB, 8'd0, c + 14));
    exp_q.push_back(mk(ST_LANE, 8'd0, c + 30));
    exp_q.push_back(mk(ST_PCS,  8'd0, c + 34));
    exp_q.push_back(mk(ST_RUN,  8'd0, c + 38));
    run_cycles(10);
    PLL_LOCK = 1'b0;
    step();
    PLL_LOCK = 1'b1;
    run_cycles(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL glitch: got no transition, expected %s", rstr(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL glitch: got %s expected %s", rstr(o), rstr(e));
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL glitch_extra: got %0d extra transitions expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_run_loss();
    rec_t e, o;
    int c;
    step();
    PLL_LOCK = 1'b0;
    c = cyc;
    step();
    PLL_LOCK = 1'b1;
    exp_q.push_back(mk(ST_WAIT, 8'd1, c + 3));
    exp_q.push_back(mk(ST_STAB, 8'd1, c + 4));
    exp_q.push_back(mk(ST_LANE, 8'd1, c + 20));
    exp_q.push_back(mk(ST_PCS,  8'd1, c + 24));
    exp_q.push_back(mk(ST_RUN,  8'd1, c + 28));
    run_cycles(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL run_loss: got no transition, expected %s", rstr(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL run_loss: got %s expected %s", rstr(o), rstr(e));
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_priority();
    rec_t e, o;
    int c;
    step();
    PLL_LOCK = 1'b0;
    c = cyc;
    run_cycles(2);
    ENABLE = 1'b0;
    exp_q.push_back(mk(ST_IDLE, 8'd1, c + 3));
    run_cycles(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL priority: got no transition, expected %s", rstr(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL priority: got %s expected %s", rstr(o), rstr(e));
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL priority_extra: got %0d extra transitions expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    rec_t e, o;
    int c;
    step();
    ENABLE = 1'b1;
    c = cyc;
    exp_q.push_back(mk(ST_WAIT,  8'd1, c + 1));
    exp_q.push_back(mk(ST_FAULT, 8'd1, c + 101));
    exp_q.push_back(mk(ST_IDLE,  8'd1, c + 111));
    exp_q.push_back(mk(ST_WAIT,  8'd1, c + 112));
    run_cycles(50);
    CLR_FAULT = 1'b1;
    step();
    CLR_FAULT = 1'b0;
    run_cycles(52);
    ENABLE = 1'b0;
    run_cycles(7);
    ENABLE    = 1'b1;
    CLR_FAULT = 1'b1;
    step();
    CLR_FAULT = 1'b0;
    run_cycles(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL timeout: got no transition, expected %s", rstr(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL timeout: got %s expected %s", rstr(o), rstr(e));
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL timeout_extra: got %0d extra transitions expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_loss_saturate();
    PLL_LOCK = 1'b1;
    run_cycles(32);
    checks++;
    if (STATE !== ST_RUN) begin
      errors++; $display("FAIL sat_start: got state %0d expected 5", STATE);
    end
    for (int i = 2; i <= 300; i++) begin
      step();
      PLL_LOCK = 1'b0;
      step();
      PLL_LOCK = 1'b1;
      run_cycles(32);
      if (i == 200 || i == 255 || i == 300) begin
        checks++;
        if (LOSS_CNT !== ((i > 255) ? 8'd255 : 8'(i))) begin
          errors++; $display("FAIL loss_count_%0d: got %0d expected %0d", i, LOSS_CNT,
                             (i > 255) ? 255 : i);
        end
        checks++;
        if (STATE !== ST_RUN || READY !== 1'b1) begin
          errors++; $display("FAIL rerun_%0d: got state %0d ready %0b expected 5 1", i, STATE, READY);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    rec_t e, o;
    int d;
    bit found;
    found = 1'b0;
    step();
    PLL_LOCK = 1'b0;
    step();
    PLL_LOCK = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (STATE === ST_PCS) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reach_pcs: got state %0d expected 4 within 40 cycles", STATE);
    end
    #1;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (STATE !== ST_IDLE) begin
      errors++; $display("FAIL async_state: got %0d expected 0", STATE);
    end
    checks++;
    if ({READY, FAULT, LANE_TX_RST_N, LANE_PCS_RST_N} !== 4'b0000) begin
      errors++; $display("FAIL async_outputs: got %b expected 0000",
                         {READY, FAULT, LANE_TX_RST_N, LANE_PCS_RST_N});
    end
    checks++;
    if (LOSS_CNT !== 8'd0) begin
      errors++; $display("FAIL async_loss: got %0d expected 0", LOSS_CNT);
    end
    step();
    obs_q.delete();
    exp_q.delete();
    RESET_N = 1'b1;
    d = cyc;
    exp_q.push_back(mk(ST_WAIT, 8'd0, d + 1));
    exp_q.push_back(mk(ST_STAB, 8'd0, d + 3));
    run_cycles(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL restart: got no transition, expected %s", rstr(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL restart: got %s expected %s", rstr(o), rstr(e));
        end
      end
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_glitch();
    test_run_loss();
    test_priority();
    test_timeout();
    test_loss_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1000000 ns");
    $fatal(1);
  end

endmodule

`default_nettype wire
